// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding and the default register-index width.
package hazard_pkg;

  // Controller FSM states; encoding is visible on the state output port.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hz_state_t;

  // Default width of a register index (32-entry register file).
  localparam int REG_W_DEF = 5;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load sitting in the DE latch
// writes a register that the instruction in the FD latch reads.
// Register 0 is hard-wired to zero, so a load into it never conflicts.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  output logic             load_use
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  assign rd_nonzero = |ex_rd;
  assign rs_match   = (ex_rd == dec_rs);
  assign rt_match   = (ex_rd == dec_rt);
  assign load_use   = ex_load & rd_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Parametrised pipeline hazard/stall controller.
// Produces per-latch enable/flush vectors for NSTAGES pipeline latches
// (latch 0 = FD ... latch NSTAGES-1 = MW) plus the PC enable. Handles
// data-memory wait states, halt drain, taken branches, jumps, load-use
// stalls and instruction-fetch misses.
// Outputs are combinational from the registered FSM state and the inputs.
// Optional feature macro: HAZARD_PERF_EN -- when defined, stall_cycles and
// flush_events are live 32-bit wrapping counters; otherwise they read 0.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NSTAGES    = 4,
  parameter int BR_LATCH   = 2,
  parameter int JMP_LATCH  = 1,
  parameter int HALT_LATCH = 3,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dREN,
  input  logic               dWEN,
  input  logic               branching,
  input  logic               jumping,
  input  logic               halt,
  input  logic               ex_load,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic [REG_W-1:0]   dec_rs,
  input  logic [REG_W-1:0]   dec_rt,
  output logic               pc_en,
  output logic [NSTAGES-1:0] en,
  output logic [NSTAGES-1:0] flush,
  output logic               halted,
  output logic [1:0]         state,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_events
);

  // Drain counter must hold up to NSTAGES-1 (halt raised at latch 0).
  localparam int CNT_W     = $clog2(NSTAGES);
  localparam int DRAIN_CNT = NSTAGES - 1 - HALT_LATCH;
  localparam logic [CNT_W-1:0]   DRAIN_INIT = CNT_W'(DRAIN_CNT);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [NSTAGES-1:0] ALL_ONES   = {NSTAGES{1'b1}};
  localparam logic [NSTAGES-1:0] FD_BIT     = NSTAGES'(1);
  localparam logic [NSTAGES-1:0] DE_BIT     = NSTAGES'(2);

  hz_state_t        state_reg;
  hz_state_t        state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             halted_reg;
  logic             halted_next;

  logic [NSTAGES-1:0] en_c;
  logic [NSTAGES-1:0] flush_c;
  logic               pc_en_c;

  logic [NSTAGES-1:0] br_mask;
  logic [NSTAGES-1:0] jmp_mask;

  logic dbusy;
  logic load_use;
  logic resolve;
  logic ihit_eff;

  // Bubble masks: a resolved branch/jump squashes every latch younger than it.
  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_masks
    assign br_mask[gi]  = (gi < BR_LATCH);
    assign jmp_mask[gi] = (gi < JMP_LATCH);
  end

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use (
    .ex_load  (ex_load),
    .ex_rd    (ex_rd),
    .dec_rs   (dec_rs),
    .dec_rt   (dec_rt),
    .load_use (load_use)
  );

  assign dbusy = (dREN | dWEN) & ~dhit;

  // The normal hazard rules apply in RUN, and also in the very cycle a
  // MEMWAIT completes so the pipe restarts without a dead cycle.
  assign resolve  = (state_reg == RUN) | ((state_reg == MEMWAIT) & dhit);
  // Fetch status is not considered while recovering from a memory wait.
  assign ihit_eff = (state_reg == MEMWAIT) ? 1'b1 : ihit;

  // Priority-ordered hazard resolution and next-state selection.
  always_comb begin
    en_c        = '0;
    flush_c     = '0;
    pc_en_c     = 1'b0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    halted_next = halted_reg;

    if (resolve) begin
      if (dbusy) begin
        // Memory not ready: freeze everything and wait.
        state_next = MEMWAIT;
      end else begin
        state_next = RUN;
        if (halt) begin
          en_c    = ALL_ONES;
          flush_c = FD_BIT;
          if (DRAIN_CNT == 0) begin
            state_next  = HALTED;
            halted_next = 1'b1;
          end else begin
            state_next = DRAIN;
            cnt_next   = DRAIN_INIT;
          end
        end else if (branching) begin
          en_c    = ALL_ONES;
          flush_c = br_mask;
          pc_en_c = 1'b1;
        end else if (jumping) begin
          en_c    = ALL_ONES;
          flush_c = jmp_mask;
          pc_en_c = 1'b1;
        end else if (load_use) begin
          // Hold FD, drop a bubble into DE, let the older stages advance.
          en_c    = ALL_ONES & ~FD_BIT;
          flush_c = DE_BIT;
        end else if (!ihit_eff) begin
          en_c    = ALL_ONES;
          flush_c = FD_BIT;
        end else begin
          en_c    = ALL_ONES;
          pc_en_c = 1'b1;
        end
      end
    end else begin
      case (state_reg)
        DRAIN: begin
          // Let older instructions retire while bubbling the front end;
          // a pending data access freezes both pipe and counter.
          if (!dbusy) begin
            en_c     = ALL_ONES;
            flush_c  = FD_BIT;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg <= CNT_ONE) begin
              state_next  = HALTED;
              halted_next = 1'b1;
            end
          end
        end
        default: begin
          // MEMWAIT without dhit, or HALTED: everything held.
        end
      endcase
    end

    if (RST) begin
      en_c    = '0;
      flush_c = ALL_ONES;
      pc_en_c = 1'b0;
    end
  end

  // FSM state, drain counter and sticky halted flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= RUN;
      cnt_reg    <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      halted_reg <= halted_next;
    end
  end

  assign en     = en_c;
  assign flush  = flush_c;
  assign pc_en  = pc_en_c;
  assign halted = halted_reg;
  assign state  = state_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_reg;
  logic [31:0] flush_ev_reg;
  logic        ctl_flush;

  // A branch or jump flush is issued only when it wins the priority chain.
  assign ctl_flush = resolve & ~dbusy & ~halt & (branching | jumping);

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_reg    <= '0;
      flush_ev_reg <= '0;
    end else begin
      if (!pc_en_c && (state_reg != HALTED)) begin
        stall_reg <= stall_reg + 32'd1;
      end
      if (ctl_flush) begin
        flush_ev_reg <= flush_ev_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_reg;
  assign flush_events = flush_ev_reg;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit. Two instances share stimulus:
// dut_a uses the default parameters (halt drain count 0) and dut_b uses
// HALT_LATCH=1 (drain count 2). A rule-level model predicts every output on
// every cycle; literal expectations pin key points of the directed sequence.
module tb_hazard_ctrl_unit;

  localparam int S_RUN = 0, S_MEMWAIT = 1, S_DRAIN = 2, S_HALTED = 3;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, dREN, dWEN, branching, jumping, halt, ex_load;
  logic [4:0] ex_rd, dec_rs, dec_rt;

  logic       pc_en_a, halted_a, pc_en_b, halted_b;
  logic [3:0] en_a, flush_a, en_b, flush_b;
  logic [1:0] state_a, state_b;
  logic [31:0] sc_a, fe_a, sc_b, fe_b;

  int nvec = 0;
  int nerr = 0;

  // Model state per instance
  int          m_st[2];
  int          m_cnt[2];
  logic [31:0] m_stall[2];
  logic [31:0] m_fev[2];

  typedef struct {
    logic [3:0] en;
    logic [3:0] flush;
    logic       pc_en;
    int         nst;
    int         ncnt;
    logic       flow;
  } mres_t;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .branching(branching), .jumping(jumping), .halt(halt),
    .ex_load(ex_load), .ex_rd(ex_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .pc_en(pc_en_a), .en(en_a), .flush(flush_a), .halted(halted_a),
    .state(state_a), .stall_cycles(sc_a), .flush_events(fe_a)
  );

  hazard_ctrl_unit #(.HALT_LATCH(1)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .branching(branching), .jumping(jumping), .halt(halt),
    .ex_load(ex_load), .ex_rd(ex_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .pc_en(pc_en_b), .en(en_b), .flush(flush_b), .halted(halted_b),
    .state(state_b), .stall_cycles(sc_b), .flush_events(fe_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // What the controller must do this cycle, from the hazard rules.
  function automatic mres_t model_step(int st, int cnt, int drain);
    mres_t r;
    logic busy, lu, ih;
    r.en = 4'b0000; r.flush = 4'b0000; r.pc_en = 1'b0;
    r.nst = st; r.ncnt = cnt; r.flow = 1'b0;
    busy = (dREN || dWEN) && !dhit;
    lu   = ex_load && (ex_rd != 0) && (ex_rd == dec_rs || ex_rd == dec_rt);
    ih   = (st == S_MEMWAIT) ? 1'b1 : ihit;
    if (st == S_RUN || (st == S_MEMWAIT && dhit)) begin
      if (busy) r.nst = S_MEMWAIT;
      else begin
        r.nst = S_RUN;
        if (halt) begin
          r.en = 4'b1111; r.flush = 4'b0001;
          if (drain == 0) r.nst = S_HALTED;
          else begin r.nst = S_DRAIN; r.ncnt = drain; end
        end else if (branching) begin
          r.en = 4'b1111; r.flush = 4'b0011; r.pc_en = 1'b1; r.flow = 1'b1;
        end else if (jumping) begin
          r.en = 4'b1111; r.flush = 4'b0001; r.pc_en = 1'b1; r.flow = 1'b1;
        end else if (lu) begin
          r.en = 4'b1110; r.flush = 4'b0010;
        end else if (!ih) begin
          r.en = 4'b1111; r.flush = 4'b0001;
        end else begin
          r.en = 4'b1111; r.pc_en = 1'b1;
        end
      end
    end else if (st == S_DRAIN && !busy) begin
      r.en = 4'b1111; r.flush = 4'b0001;
      r.ncnt = cnt - 1;
      if (r.ncnt == 0) r.nst = S_HALTED;
    end
    if (RST) begin
      r.en = 4'b0000; r.flush = 4'b1111; r.pc_en = 1'b0;
    end
    return r;
  endfunction

  task automatic check_dut(input int k, input int drain,
                           input logic [3:0] en_act, input logic [3:0] fl_act,
                           input logic pc_act, input logic hl_act,
                           input logic [1:0] st_act,
                           input logic [31:0] sc_act, input logic [31:0] fe_act);
    mres_t r;
    string p;
    p = (k == 0) ? "a" : "b";
    r = model_step(m_st[k], m_cnt[k], drain);
    chk({p, ".en"}, {28'd0, en_act}, {28'd0, r.en});
    chk({p, ".flush"}, {28'd0, fl_act}, {28'd0, r.flush});
    chk({p, ".pc_en"}, {31'd0, pc_act}, {31'd0, r.pc_en});
    chk({p, ".state"}, {30'd0, st_act}, m_st[k]);
    chk({p, ".halted"}, {31'd0, hl_act}, (m_st[k] == S_HALTED) ? 32'd1 : 32'd0);
`ifdef HAZARD_PERF_EN
    chk({p, ".stall_cycles"}, sc_act, m_stall[k]);
    chk({p, ".flush_events"}, fe_act, m_fev[k]);
`else
    chk({p, ".stall_cycles"}, sc_act, 32'd0);
    chk({p, ".flush_events"}, fe_act, 32'd0);
`endif
    if (RST) begin
      m_st[k] = S_RUN; m_cnt[k] = 0; m_stall[k] = 32'd0; m_fev[k] = 32'd0;
    end else begin
      if (!r.pc_en && m_st[k] != S_HALTED) m_stall[k] = m_stall[k] + 32'd1;
      if (r.flow) m_fev[k] = m_fev[k] + 32'd1;
      m_st[k] = r.nst;
      m_cnt[k] = r.ncnt;
    end
  endtask

  // Per-cycle compare process, sampling on the falling edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_RUN; m_cnt[k] = 0; m_stall[k] = 32'd0; m_fev[k] = 32'd0;
    end
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      check_dut(0, 0, en_a, flush_a, pc_en_a, halted_a, state_a, sc_a, fe_a);
      check_dut(1, 2, en_b, flush_b, pc_en_b, halted_b, state_b, sc_b, fe_b);
    end
  end

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    branching = 1'b0; jumping = 1'b0; halt = 1'b0;
    ex_load = 1'b0; ex_rd = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    RST = 1'b1;
    idle();
    repeat (2) begin
      look();
      chk("rst.en", {28'd0, en_a}, 32'h0);
      chk("rst.flush", {28'd0, flush_a}, 32'hf);
      chk("rst.pc_en", {31'd0, pc_en_a}, 32'd0);
      step();
    end
    RST = 1'b0;
    look();
    chk("run.en", {28'd0, en_a}, 32'hf);
    chk("run.flush", {28'd0, flush_a}, 32'h0);
    chk("run.pc_en", {31'd0, pc_en_a}, 32'd1);
    chk("run.state", {30'd0, state_a}, 32'd0);
    step();

    // Data-memory wait for three cycles, then completion.
    dREN = 1'b1; dhit = 1'b0;
    look(); chk("mw0.en", {28'd0, en_a}, 32'h0); chk("mw0.state", {30'd0, state_a}, 32'd0); step();
    look(); chk("mw1.en", {28'd0, en_a}, 32'h0); chk("mw1.state", {30'd0, state_a}, 32'd1); step();
    look(); chk("mw2.en", {28'd0, en_a}, 32'h0); chk("mw2.state", {30'd0, state_a}, 32'd1); step();
    dhit = 1'b1;
    look(); chk("mwhit.en", {28'd0, en_a}, 32'hf); chk("mwhit.state", {30'd0, state_a}, 32'd1); step();
    idle();
    look(); chk("mwdone.state", {30'd0, state_a}, 32'd0); step();

    // Branch beats load-use and fetch miss.
    branching = 1'b1; ex_load = 1'b1; ex_rd = 5'd5; dec_rt = 5'd5; ihit = 1'b0;
    look();
    chk("br.flush", {28'd0, flush_a}, 32'h3);
    chk("br.pc_en", {31'd0, pc_en_a}, 32'd1);
    step();
    idle();
    look();
`ifdef HAZARD_PERF_EN
    chk("perf.stall", sc_a, 32'd3);
    chk("perf.flush", fe_a, 32'd1);
`else
    chk("perf.stall", sc_a, 32'd0);
    chk("perf.flush", fe_a, 32'd0);
`endif
    step();

    // Jump alone.
    jumping = 1'b1;
    look(); chk("jmp.flush", {28'd0, flush_a}, 32'h1); chk("jmp.pc_en", {31'd0, pc_en_a}, 32'd1); step();
    idle();

    // Load-use stall, then the same with destination r0.
    ex_load = 1'b1; ex_rd = 5'd5; dec_rt = 5'd5;
    look();
    chk("lu.pc_en", {31'd0, pc_en_a}, 32'd0);
    chk("lu.en", {28'd0, en_a}, 32'he);
    chk("lu.flush", {28'd0, flush_a}, 32'h2);
    step();
    ex_rd = 5'd0; dec_rt = 5'd0;
    look(); chk("lu0.pc_en", {31'd0, pc_en_a}, 32'd1); chk("lu0.flush", {28'd0, flush_a}, 32'h0); step();
    idle();

    // Fetch miss.
    ihit = 1'b0;
    look(); chk("imiss.pc_en", {31'd0, pc_en_a}, 32'd0); chk("imiss.flush", {28'd0, flush_a}, 32'h1); step();
    idle();

    // Jump beats load-use on rs.
    jumping = 1'b1; ex_load = 1'b1; ex_rd = 5'd7; dec_rs = 5'd7;
    look(); chk("jlu.flush", {28'd0, flush_a}, 32'h1); chk("jlu.pc_en", {31'd0, pc_en_a}, 32'd1); step();
    idle();

    // Reset in the middle of a memory wait.
    dWEN = 1'b1;
    step();
    RST = 1'b1;
    look(); chk("rmw.state", {30'd0, state_a}, 32'd1); chk("rmw.flush", {28'd0, flush_a}, 32'hf); step();
    RST = 1'b0; idle();
    look(); chk("rmw.after", {30'd0, state_a}, 32'd0); step();

    // Halt: dut_a halts at once, dut_b drains two cycles first.
    halt = 1'b1;
    look(); chk("halt.en", {28'd0, en_b}, 32'hf); chk("halt.flush", {28'd0, flush_b}, 32'h1); step();
    look();
    chk("a.halted", {31'd0, halted_a}, 32'd1);
    chk("b.drain1", {30'd0, state_b}, 32'd2);
    chk("b.drain1.flush", {28'd0, flush_b}, 32'h1);
    step();
    halt = 1'b0; dREN = 1'b1; dhit = 1'b0;
    look(); chk("b.frozen.en", {28'd0, en_b}, 32'h0); chk("b.frozen.state", {30'd0, state_b}, 32'd2); step();
    idle();
    look(); chk("b.drain2.flush", {28'd0, flush_b}, 32'h1); step();
    branching = 1'b1;
    look();
    chk("b.halted", {31'd0, halted_b}, 32'd1);
    chk("b.halted.pc_en", {31'd0, pc_en_b}, 32'd0);
    chk("b.halted.flush", {28'd0, flush_b}, 32'h0);
    step();
    idle();
    look(); chk("a.halted.hold", {31'd0, halted_a}, 32'd1); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    look();
    chk("a.unhalt", {31'd0, halted_a}, 32'd0);
    chk("b.unhalt", {31'd0, halted_b}, 32'd0);
    chk("b.unhalt.state", {30'd0, state_b}, 32'd0);
    step();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
